// File: rtl/sa_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_stream_pkg : shared geometry, flag positions and packer FSM states |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sa_stream_pkg;

  localparam int N           = 8;
  localparam int M           = 7;
  localparam int ARITH_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  function automatic int sob_bit(input int data_width);
    return data_width - 2;
  endfunction

  function automatic int eob_bit(input int data_width);
    return data_width - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_out_reg : single-entry valid/ready output register, load & drain   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sa_out_reg #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rtr_i,
  output logic             rts_o,
  output logic [WIDTH-1:0] data_o
);

  logic             r_vld;
  logic [WIDTH-1:0] r_data;

  // A load in the same cycle as a drain simply overwrites, so no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (load_i) begin
      r_vld  <= 1'b1;
      r_data <= data_i;
    end else if (rtr_i) begin
      r_vld  <= 1'b0;
    end
  end

  assign rts_o  = r_vld;
  assign data_o = r_data;

endmodule
`default_nettype wire

// File: rtl/sa_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_stream_packer : joins A and B operand beats into flagged SA words  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sa_stream_packer
  import sa_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [CNT_WIDTH-1:0]      k_len_i,
  input  logic [CNT_WIDTH-1:0]      n_blocks_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic                      a_rts_i,
  output logic                      a_rtr_o,
  input  logic [N*ARITH_WIDTH-1:0]  a_data_i,
  input  logic                      b_rts_i,
  output logic                      b_rtr_o,
  input  logic [M*ARITH_WIDTH-1:0]  b_data_i,
  output logic                      rts_o,
  input  logic                      rtr_i,
  output logic [DATA_WIDTH-1:0]     data_o
);

  localparam int C_A_W = N * ARITH_WIDTH;
  localparam int C_B_W = M * ARITH_WIDTH;
  localparam int C_SOB = sob_bit(DATA_WIDTH);
  localparam int C_EOB = eob_bit(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] C_ONE = 1;

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_k_len, r_n_blocks, r_beat_cnt, r_blk_cnt;
  logic                  r_done, w_done_nxt;
  logic                  w_room, w_load, w_accept, w_last_beat, w_last_blk;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_room      = ~rts_o | rtr_i;
  assign w_last_beat = (r_beat_cnt == r_k_len - C_ONE);
  assign w_last_blk  = (r_blk_cnt == r_n_blocks - C_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Both ready outputs depend on the opposite valid: beats are only ever taken as a pair.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    a_rtr_o     = 1'b0;
    b_rtr_o     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          if ((k_len_i == '0) || (n_blocks_i == '0)) begin
            w_done_nxt = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = STREAM;
          end
        end
      end
      STREAM: begin
        a_rtr_o = b_rts_i & w_room;
        b_rtr_o = a_rts_i & w_room;
        w_load  = a_rts_i & b_rts_i & w_room;
        if (w_load && w_last_beat && w_last_blk) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (rts_o && rtr_i) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_len    <= '0;
      r_n_blocks <= '0;
      r_beat_cnt <= '0;
      r_blk_cnt  <= '0;
    end else if (w_accept) begin
      r_k_len    <= k_len_i;
      r_n_blocks <= n_blocks_i;
      r_beat_cnt <= '0;
      r_blk_cnt  <= '0;
    end else if (w_load) begin
      if (w_last_beat) begin
        r_beat_cnt <= '0;
        r_blk_cnt  <= r_blk_cnt + C_ONE;
      end else begin
        r_beat_cnt <= r_beat_cnt + C_ONE;
      end
    end
  end

  always_comb begin
    w_word                   = '0;
    w_word[C_A_W-1:0]        = a_data_i;
    w_word[C_A_W+C_B_W-1:C_A_W] = b_data_i;
    w_word[C_SOB]            = (r_beat_cnt == '0);
    w_word[C_EOB]            = w_last_beat;
  end

  sa_out_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (w_load),
    .data_i (w_word),
    .rtr_i  (rtr_i),
    .rts_o  (rts_o),
    .data_o (data_o)
  );

  assign busy_o = (r_state != IDLE);
  assign done_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sa_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sa_stream_packer : randomized bench with a queue-based word model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sa_stream_packer;

  localparam int DW = 1024;
  localparam int CW = 16;
  localparam int AW = 512;
  localparam int BW = 448;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [CW-1:0] k_len_i, n_blocks_i;
  logic          busy_o, done_o;
  logic          a_rts_i, a_rtr_o, b_rts_i, b_rtr_o;
  logic [AW-1:0] a_data_i;
  logic [BW-1:0] b_data_i;
  logic          rts_o, rtr_i;
  logic [DW-1:0] data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sa_stream_packer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i),
    .n_blocks_i(n_blocks_i), .busy_o(busy_o), .done_o(done_o),
    .a_rts_i(a_rts_i), .a_rtr_o(a_rtr_o), .a_data_i(a_data_i),
    .b_rts_i(b_rts_i), .b_rtr_o(b_rtr_o), .b_data_i(b_data_i),
    .rts_o(rts_o), .rtr_i(rtr_i), .data_o(data_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      int idx;
      idx = 0;
      for (int i = 15; i >= 0; i--) if (obs[i*64 +: 64] !== exp[i*64 +: 64]) idx = i;
      errors++;
      $error("FAIL %s chunk=%0d observed=%h expected=%h", tag, idx,
             obs[idx*64 +: 64], exp[idx*64 +: 64]);
    end
  endtask

  function automatic logic [AW-1:0] rand_a();
    logic [AW-1:0] v;
    for (int i = 0; i < AW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [BW-1:0] rand_b();
    logic [BW-1:0] v;
    for (int i = 0; i < BW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Word layout expected by the SA wrapper: A low, B above it, flags at the top.
  function automatic logic [DW-1:0] fmt(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                        input bit sob, input bit eob);
    logic [DW-1:0] w;
    w = '0;
    w[AW-1:0] = a;
    w[AW+BW-1:AW] = b;
    w[DW-2] = sob;
    w[DW-1] = eob;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 1'b0;
    a_rts_i = 1'b0;
    b_rts_i = 1'b0;
    rtr_i   = 1'b1;
  endtask

  task automatic run_job(input int k, input int nb, input int p_rtr, input int p_a,
                         input int p_b, input int abort_after, input bit check_span);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] held;
    logic [AW-1:0] cur_a;
    logic [BW-1:0] cur_b;
    bit held_vld, finished, aborted;
    int total, joined, outcnt, cyc, first_cyc, last_cyc;
    total = k * nb; joined = 0; outcnt = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
    held_vld = 0; held = '0; finished = 0; aborted = 0;
    cur_a = rand_a(); cur_b = rand_b();
    start_i = 1'b1; k_len_i = CW'(k); n_blocks_i = CW'(nb);
    step();
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    while (cyc < 4000) begin
      a_rts_i  = ($urandom_range(0, 99) < p_a);
      b_rts_i  = ($urandom_range(0, 99) < p_b);
      rtr_i    = ($urandom_range(0, 99) < p_rtr);
      a_data_i = cur_a;
      b_data_i = cur_b;
      start_i    = ($urandom_range(0, 7) == 0);
      k_len_i    = CW'($urandom_range(1, 3));
      n_blocks_i = 1;
      #1;
      chk("a_rtr", a_rtr_o, (joined < total) && b_rts_i && (!rts_o || rtr_i));
      chk("b_rtr", b_rtr_o, (joined < total) && a_rts_i && (!rts_o || rtr_i));
      chk("done_mid_job", done_o, 0);
      if (held_vld) begin
        chk("hold_valid", rts_o, 1);
        chk_word("hold_data", data_o, held);
      end
      if (rts_o && rtr_i) begin
        chk("word_pending", outcnt < exp_q.size(), 1);
        if (outcnt < exp_q.size()) chk_word("word", data_o, exp_q[outcnt]);
        if (outcnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        outcnt++;
      end
      held_vld = rts_o && !rtr_i;
      held = data_o;
      if (a_rts_i && a_rtr_o && b_rts_i && b_rtr_o) begin
        exp_q.push_back(fmt(cur_a, cur_b, (joined % k) == 0, (joined % k) == k - 1));
        joined++;
        cur_a = rand_a();
        cur_b = rand_b();
      end
      step();
      cyc++;
      if (abort_after >= 0 && outcnt == abort_after) begin aborted = 1; break; end
      if (outcnt == total) begin finished = 1; break; end
    end
    if (aborted) begin
      idle_inputs();
      a_rts_i = 1'b1; b_rts_i = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("rst_rts", rts_o, 0);
      chk_word("rst_data", data_o, '0);
      chk("rst_done", done_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_a_rtr", a_rtr_o, 0);
      chk("rst_b_rtr", b_rtr_o, 0);
      idle_inputs();
      step();
      rst_n = 1'b1;
      step();
    end else begin
      idle_inputs();
      if (!finished) begin
        checks++; errors++;
        $error("FAIL job_timeout observed=%0d words expected=%0d", outcnt, total);
      end
      #1;
      chk("joined_count", joined, total);
      chk("done_pulse", done_o, 1);
      chk("busy_end", busy_o, 0);
      chk("no_extra_word", rts_o, 0);
      if (check_span) chk("back_to_back_span", last_cyc - first_cyc, total - 1);
      step();
      chk("done_clears", done_o, 0);
    end
  endtask

  initial begin
    logic [AW-1:0] sa;
    logic [BW-1:0] sb;
    rst_n = 1'b0;
    idle_inputs();
    k_len_i = '0; n_blocks_i = '0; a_data_i = '0; b_data_i = '0;
    repeat (3) step();
    chk("reset_rts", rts_o, 0);
    chk_word("reset_data", data_o, '0);
    chk("reset_done", done_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_a_rtr", a_rtr_o, 0);
    chk("reset_b_rtr", b_rtr_o, 0);
    rst_n = 1'b1;
    step();

    run_job(4, 2, 100, 100, 100, -1, 1);
    run_job(1, 3, 100, 100, 100, -1, 0);
    run_job(5, 4, 50, 100, 100, -1, 0);
    run_job(3, 3, 60, 70, 70, -1, 0);

    // A waits alone: nothing may be consumed until B shows up.
    start_i = 1'b1; k_len_i = 1; n_blocks_i = 1;
    step();
    start_i = 1'b0;
    sa = rand_a(); sb = rand_b();
    a_data_i = sa; b_data_i = sb; a_rts_i = 1'b1; b_rts_i = 1'b0; rtr_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("a_alone_rtr", a_rtr_o, 0);
      chk("a_alone_rts", rts_o, 0);
      step();
    end
    b_rts_i = 1'b1;
    #1;
    chk("join_a_rtr", a_rtr_o, 1);
    chk("join_b_rtr", b_rtr_o, 1);
    step();
    a_rts_i = 1'b0; b_rts_i = 1'b0;
    #1;
    chk("join_rts", rts_o, 1);
    chk_word("join_word", data_o, fmt(sa, sb, 1'b1, 1'b1));
    step();
    chk("join_done", done_o, 1);
    chk("join_single", rts_o, 0);
    step();

    start_i = 1'b1; k_len_i = 0; n_blocks_i = 2;
    step();
    start_i = 1'b0;
    chk("klen0_done", done_o, 1);
    chk("klen0_busy", busy_o, 0);
    chk("klen0_rts", rts_o, 0);
    step();
    chk("klen0_done_clear", done_o, 0);
    chk("klen0_rts_later", rts_o, 0);
    start_i = 1'b1; k_len_i = 3; n_blocks_i = 0;
    step();
    start_i = 1'b0;
    chk("nblk0_done", done_o, 1);
    chk("nblk0_busy", busy_o, 0);
    step();

    run_job(8, 1, 100, 100, 100, 3, 0);
    run_job(3, 2, 100, 80, 80, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
